// File: rtl/fetch_stage_pkg.sv
// Shared widths, reset PC and the fetch-to-decode bundle layout.
package fetch_stage_pkg;

  localparam int unsigned DBITS      = 32;
  localparam int unsigned INST_BITS  = 32;
  localparam int unsigned BHR_BITS   = 8;
  localparam int unsigned INSTSIZE   = 4;
  localparam logic [DBITS-1:0] START_PC = 32'h0000_0100;

  localparam int unsigned ENTRY_BITS = INST_BITS + DBITS + BHR_BITS;
  localparam int unsigned FE_DE_BITS = 1 + ENTRY_BITS;

  // One buffered instruction with the PC and history it was fetched under.
  typedef struct packed {
    logic [INST_BITS-1:0] inst;
    logic [DBITS-1:0]     pc;
    logic [BHR_BITS-1:0]  bhr;
  } fe_entry_t;

  typedef struct packed {
    logic      valid;
    fe_entry_t entry;
  } fe_to_de_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO; entry 0 is always the head presented to decode.
module fetch_queue
  import fetch_stage_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [ENTRY_BITS-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [1:0]            count_o,
  output logic [ENTRY_BITS-1:0] head_o
);

  logic [ENTRY_BITS-1:0] ent0_q, ent0_d;
  logic [ENTRY_BITS-1:0] ent1_q, ent1_d;
  logic [1:0]            count_q, count_d;
  logic                  do_pop;

  assign do_pop = pop_i && (count_q != 2'd0);

  // Pop shifts entry 1 forward; push lands in the first slot left free after the pop.
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (clear_i) begin
      count_d = 2'd0;
    end else begin
      if (do_pop) begin
        ent0_d  = ent1_q;
        count_d = count_q - 2'd1;
      end
      if (push_i) begin
        if (count_d == 2'd0) begin
          ent0_d = push_data_i;
        end else begin
          ent1_d = push_data_i;
        end
        count_d = count_d + 2'd1;
      end
    end
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = ent0_q;

  // Upstream issue gating must never let a push land on a full queue.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && !clear_i && !do_pop && count_q == 2'd2));

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the fetch PC, issues 1-cycle imem reads, buffers results for decode.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [DBITS-1:0]     fe_pc,
  input  logic                 bp_flush,
  input  logic [DBITS-1:0]     bp_new_pc,
  input  logic [BHR_BITS-1:0]  bp_bhr,
  output logic                 imem_req,
  output logic [DBITS-1:0]     imem_addr,
  input  logic [INST_BITS-1:0] imem_rdata,
  input  logic                 de_stall,
  output logic                 fe_valid,
  output logic [INST_BITS-1:0] fe_inst,
  output logic [DBITS-1:0]     fe_inst_pc,
  output logic [BHR_BITS-1:0]  fe_inst_bhr
);

  logic [DBITS-1:0]      pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [DBITS-1:0]      tag_pc_q, tag_pc_d;
  logic [BHR_BITS-1:0]   tag_bhr_q, tag_bhr_d;
  logic [1:0]            count;
  logic [2:0]            occ;
  logic                  pop, push, issue;
  logic [ENTRY_BITS-1:0] head_raw, push_raw;
  fe_entry_t             push_entry;
  fe_to_de_t             de_out;

  assign pop = (count != 2'd0) && !de_stall;
  // Slots committed after this edge: buffered + pending response - departing head.
  assign occ   = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = reset && !bp_flush && (occ < 3'd2);
  // A flush squashes the response arriving in the same cycle.
  assign push  = inflight_q && !bp_flush;

  assign push_entry = '{inst: imem_rdata, pc: tag_pc_q, bhr: tag_bhr_q};
  assign push_raw   = push_entry;

  // Next PC, in-flight flag and request tag; flush overrides issue.
  always_comb begin
    pc_d       = pc_q;
    inflight_d = 1'b0;
    tag_pc_d   = tag_pc_q;
    tag_bhr_d  = tag_bhr_q;
    if (bp_flush) begin
      pc_d = bp_new_pc;
    end else if (issue) begin
      pc_d       = bp_new_pc;
      inflight_d = 1'b1;
      tag_pc_d   = pc_q;
      tag_bhr_d  = bp_bhr;
    end
  end

  // PC, in-flight and tag state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= START_PC;
      inflight_q <= 1'b0;
      tag_pc_q   <= '0;
      tag_bhr_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      tag_pc_q   <= tag_pc_d;
      tag_bhr_q  <= tag_bhr_d;
    end
  end

  fetch_queue u_queue (
    .clk_i       (clk),
    .rst_ni      (reset),
    .clear_i     (bp_flush),
    .push_i      (push),
    .push_data_i (push_raw),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head_raw)
  );

  // Decode-facing bundle straight from the registered queue head.
  always_comb begin
    de_out       = '0;
    de_out.valid = (count != 2'd0);
    de_out.entry = fe_entry_t'(head_raw);
  end

  assign fe_pc       = pc_q;
  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign fe_valid    = de_out.valid;
  assign fe_inst     = de_out.entry.inst;
  assign fe_inst_pc  = de_out.entry.pc;
  assign fe_inst_bhr = de_out.entry.bhr;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: transaction-level model plus directed literal checkpoints.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DBITS-1:0]     fe_pc;
  logic                 bp_flush;
  logic [DBITS-1:0]     bp_new_pc;
  logic [BHR_BITS-1:0]  bp_bhr;
  logic                 imem_req;
  logic [DBITS-1:0]     imem_addr;
  logic [INST_BITS-1:0] imem_rdata = '0;
  logic                 de_stall;
  logic                 fe_valid;
  logic [INST_BITS-1:0] fe_inst;
  logic [DBITS-1:0]     fe_inst_pc;
  logic [BHR_BITS-1:0]  fe_inst_bhr;
  logic [DBITS-1:0]     tgt;

  int checks = 0;
  int errors = 0;

  // Simple predictor: sequential next PC unless redirecting.
  assign bp_new_pc = bp_flush ? tgt : fe_pc + 32'(INSTSIZE);

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .fe_pc      (fe_pc),
    .bp_flush   (bp_flush),
    .bp_new_pc  (bp_new_pc),
    .bp_bhr     (bp_bhr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .de_stall   (de_stall),
    .fe_valid   (fe_valid),
    .fe_inst    (fe_inst),
    .fe_inst_pc (fe_inst_pc),
    .fe_inst_bhr(fe_inst_bhr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of fetched transactions plus one outstanding request.
  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [7:0]  bhr;
  } ent_t;

  ent_t        mq[$];
  bit          m_inf = 1'b0;
  logic [31:0] m_inf_pc = '0;
  logic [7:0]  m_inf_bhr = '0;
  logic [31:0] m_pc = START_PC;

  // Values sampled mid-cycle, consumed at the following rising edge.
  bit          s_flush = 1'b0, s_req = 1'b0, s_pop = 1'b0, s_dreq = 1'b0;
  logic [31:0] s_newpc = '0, s_daddr = '0;
  logic [7:0]  s_bhr = '0;

  always @(negedge clk) begin : cmp
    int n;
    int p;
    bit req;
    n   = mq.size();
    p   = (reset && n != 0 && !de_stall) ? 1 : 0;
    req = reset && !bp_flush && (n + int'(m_inf) - p < 2);
    chk("imem_req", 64'(imem_req), 64'(req));
    if (req) chk("imem_addr", 64'(imem_addr), 64'(m_pc));
    chk("fe_pc", 64'(fe_pc), 64'(m_pc));
    chk("fe_valid", 64'(fe_valid), 64'(n != 0));
    if (n != 0) begin
      chk("fe_inst", 64'(fe_inst), 64'(mq[0].inst));
      chk("fe_inst_pc", 64'(fe_inst_pc), 64'(mq[0].pc));
      chk("fe_inst_bhr", 64'(fe_inst_bhr), 64'(mq[0].bhr));
    end
    s_flush = bp_flush;
    s_req   = req;
    s_pop   = (p != 0);
    s_newpc = bp_new_pc;
    s_bhr   = bp_bhr;
    s_dreq  = imem_req;
    s_daddr = imem_addr;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = START_PC;
    end else if (s_flush) begin
      mq.delete();
      m_inf = 1'b0;
      m_pc  = s_newpc;
    end else begin
      if (s_pop) void'(mq.pop_front());
      if (m_inf) mq.push_back('{mem_word(m_inf_pc), m_inf_pc, m_inf_bhr});
      if (s_req) begin
        m_inf     = 1'b1;
        m_inf_pc  = m_pc;
        m_inf_bhr = s_bhr;
        m_pc      = s_newpc;
      end else begin
        m_inf = 1'b0;
      end
    end
  end

  // Memory: answers the previous cycle's request, otherwise returns junk.
  always @(posedge clk) begin
    imem_rdata <= s_dreq ? mem_word(s_daddr) : $urandom;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; bp_flush = 1'b0; de_stall = 1'b0; tgt = '0; bp_bhr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst fe_valid", 64'(fe_valid), 64'd0);
    chk("rst imem_req", 64'(imem_req), 64'd0);
    chk("rst fe_inst", 64'(fe_inst), 64'd0);
    chk("rst fe_inst_pc", 64'(fe_inst_pc), 64'd0);
    chk("rst fe_inst_bhr", 64'(fe_inst_bhr), 64'd0);
    chk("rst fe_pc", 64'(fe_pc), 64'h100);

    // Cycles 0..2: back-to-back fetch from 0x100.
    reset = 1'b1; bp_bhr = 8'h10; #1;
    chk("c0 req", 64'(imem_req), 64'd1);
    chk("c0 addr", 64'(imem_addr), 64'h100);
    next_cycle(); bp_bhr = 8'h11; #1;
    chk("c1 addr", 64'(imem_addr), 64'h104);
    chk("c1 valid", 64'(fe_valid), 64'd0);
    next_cycle(); bp_bhr = 8'h12; #1;
    chk("c2 addr", 64'(imem_addr), 64'h108);
    chk("c2 valid", 64'(fe_valid), 64'd1);
    chk("c2 inst_pc", 64'(fe_inst_pc), 64'h100);
    chk("c2 inst_bhr", 64'(fe_inst_bhr), 64'h10);

    // Cycles 3..6: stall, queue fills and fetch PC holds.
    next_cycle(); de_stall = 1'b1; bp_bhr = 8'h13; #1;
    chk("c3 inst_pc", 64'(fe_inst_pc), 64'h104);
    chk("c3 req", 64'(imem_req), 64'd0);
    next_cycle(); #1;
    chk("c4 req", 64'(imem_req), 64'd0);
    chk("c4 fe_pc", 64'(fe_pc), 64'h10C);
    next_cycle(); #1;
    next_cycle(); #1;
    chk("c6 fe_pc", 64'(fe_pc), 64'h10C);
    chk("c6 inst_pc", 64'(fe_inst_pc), 64'h104);

    // Cycle 7: release; issue resumes alongside the first dequeue, BHR tagged A5.
    next_cycle(); de_stall = 1'b0; bp_bhr = 8'hA5; #1;
    chk("c7 req", 64'(imem_req), 64'd1);
    chk("c7 addr", 64'(imem_addr), 64'h10C);
    next_cycle(); bp_bhr = 8'h3C; #1;
    chk("c8 inst_pc", 64'(fe_inst_pc), 64'h108);
    chk("c8 addr", 64'(imem_addr), 64'h110);
    next_cycle(); bp_bhr = 8'h3D; #1;
    chk("c9 inst_pc", 64'(fe_inst_pc), 64'h10C);
    chk("c9 inst_bhr", 64'(fe_inst_bhr), 64'hA5);

    // Cycles 10..12: fill queue, then flush together with stall.
    next_cycle(); de_stall = 1'b1; #1;
    next_cycle(); #1;
    chk("c11 req", 64'(imem_req), 64'd0);
    next_cycle(); bp_flush = 1'b1; tgt = 32'h200; #1;
    chk("c12 flush req", 64'(imem_req), 64'd0);
    next_cycle(); bp_flush = 1'b0; de_stall = 1'b0; #1;
    chk("c13 valid", 64'(fe_valid), 64'd0);
    chk("c13 addr", 64'(imem_addr), 64'h200);
    chk("c13 fe_pc", 64'(fe_pc), 64'h200);
    next_cycle(); #1;
    chk("c14 addr", 64'(imem_addr), 64'h204);
    chk("c14 valid", 64'(fe_valid), 64'd0);
    next_cycle(); #1;
    chk("c15 valid", 64'(fe_valid), 64'd1);
    chk("c15 inst_pc", 64'(fe_inst_pc), 64'h200);
    chk("c15 inst", 64'(fe_inst), 64'(mem_word(32'h200)));

    // Flush with a response in flight, then a redirect that wraps the PC.
    next_cycle(); bp_flush = 1'b1; tgt = 32'h300; #1;
    next_cycle(); bp_flush = 1'b0; #1;
    chk("c17 valid", 64'(fe_valid), 64'd0);
    chk("c17 addr", 64'(imem_addr), 64'h300);
    next_cycle(); bp_flush = 1'b1; tgt = 32'hFFFF_FFFC; #1;
    next_cycle(); bp_flush = 1'b0; #1;
    chk("c19 addr", 64'(imem_addr), 64'hFFFF_FFFC);
    next_cycle(); #1;
    chk("c20 wrap addr", 64'(imem_addr), 64'h0);
    next_cycle(); #1;
    chk("c21 inst_pc", 64'(fe_inst_pc), 64'hFFFF_FFFC);

    // Mixed traffic checked by the model.
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      de_stall = ($urandom_range(0, 2) == 0);
      bp_flush = ($urandom_range(0, 9) == 0);
      tgt      = $urandom & 32'hFFFF_FFFC;
      bp_bhr   = 8'($urandom);
    end

    // Fill the queue, then assert reset mid-cycle.
    next_cycle(); bp_flush = 1'b0; de_stall = 1'b1;
    repeat (3) next_cycle();
    @(posedge clk); #2;
    reset = 1'b0; de_stall = 1'b0; #1;
    chk("arst valid", 64'(fe_valid), 64'd0);
    chk("arst req", 64'(imem_req), 64'd0);
    chk("arst fe_pc", 64'(fe_pc), 64'h100);
    next_cycle(); reset = 1'b1; #1;
    chk("rr c0 addr", 64'(imem_addr), 64'h100);
    chk("rr c0 req", 64'(imem_req), 64'd1);
    next_cycle(); #1;
    next_cycle(); #1;
    chk("rr c2 valid", 64'(fe_valid), 64'd1);
    chk("rr c2 inst_pc", 64'(fe_inst_pc), 64'h100);
    repeat (4) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
